// File: rtl/muladd_pipe.sv
// Pipelined multiply-add/accumulate: q = a*b + {0 | q | c}, with optional input
// register, signed/unsigned operands and wrap or saturate on overflow.
module muladd_pipe #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 20,
    parameter int IN_REG    = 0,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 0
) (
    input  logic                 UserCLK,
    input  logic                 RESETn,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic [ACC_WIDTH-1:0] c,
    input  logic                 acc_en,
    input  logic                 clr,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] q,
    output logic                 ovf
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int S_WIDTH = ACC_WIDTH + 1;

    generate
        if (ACC_WIDTH < P_WIDTH) begin : g_bad_width
            $error("muladd_pipe: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
        end
    endgenerate

    logic [A_WIDTH-1:0]   w_a;
    logic [B_WIDTH-1:0]   w_b;
    logic [ACC_WIDTH-1:0] w_c;
    logic                 w_clr;
    logic                 w_acc_en;
    logic                 w_vld;

    generate
        if (IN_REG != 0) begin : g_in_reg
            logic [A_WIDTH-1:0]   r_a;
            logic [B_WIDTH-1:0]   r_b;
            logic [ACC_WIDTH-1:0] r_c;
            logic                 r_clr;
            logic                 r_acc_en;
            logic                 r_vld;

            always_ff @(posedge UserCLK or negedge RESETn) begin
                if (!RESETn) begin
                    r_a      <= '0;
                    r_b      <= '0;
                    r_c      <= '0;
                    r_clr    <= 1'b0;
                    r_acc_en <= 1'b0;
                    r_vld    <= 1'b0;
                end else if (ce) begin
                    r_a      <= a;
                    r_b      <= b;
                    r_c      <= c;
                    r_clr    <= clr;
                    r_acc_en <= acc_en;
                    r_vld    <= in_valid;
                end
            end

            assign w_a      = r_a;
            assign w_b      = r_b;
            assign w_c      = r_c;
            assign w_clr    = r_clr;
            assign w_acc_en = r_acc_en;
            assign w_vld    = r_vld;
        end else begin : g_in_comb
            assign w_a      = a;
            assign w_b      = b;
            assign w_c      = c;
            assign w_clr    = clr;
            assign w_acc_en = acc_en;
            assign w_vld    = in_valid;
        end
    endgenerate

    // Extending both operands to the full product width makes the low P_WIDTH
    // bits of an unsigned multiply equal to the two's-complement product.
    logic [P_WIDTH-1:0] w_a_ext;
    logic [P_WIDTH-1:0] w_b_ext;
    logic [P_WIDTH-1:0] w_prod;

    assign w_a_ext = (SIGNED != 0) ? {{B_WIDTH{w_a[A_WIDTH-1]}}, w_a} : {{B_WIDTH{1'b0}}, w_a};
    assign w_b_ext = (SIGNED != 0) ? {{A_WIDTH{w_b[B_WIDTH-1]}}, w_b} : {{A_WIDTH{1'b0}}, w_b};
    assign w_prod  = w_a_ext * w_b_ext;

    logic [P_WIDTH-1:0]   r_p;
    logic [ACC_WIDTH-1:0] r_c_m;
    logic                 r_clr_m;
    logic                 r_acc_en_m;
    logic                 r_vld_m;

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            r_p        <= '0;
            r_c_m      <= '0;
            r_clr_m    <= 1'b0;
            r_acc_en_m <= 1'b0;
            r_vld_m    <= 1'b0;
        end else if (ce) begin
            r_p        <= w_prod;
            r_c_m      <= w_c;
            r_clr_m    <= w_clr;
            r_acc_en_m <= w_acc_en;
            r_vld_m    <= w_vld;
        end
    end

    logic [ACC_WIDTH-1:0] r_q;
    logic                 r_ovf;
    logic                 r_out_valid;

    logic [S_WIDTH-1:0]   w_p_ext;
    logic [S_WIDTH-1:0]   w_base;
    logic [S_WIDTH-1:0]   w_sum;
    logic                 w_over;
    logic [ACC_WIDTH-1:0] w_sat_val;
    logic [ACC_WIDTH-1:0] w_result;

    assign w_p_ext = (SIGNED != 0) ? {{(S_WIDTH-P_WIDTH){r_p[P_WIDTH-1]}}, r_p}
                                   : {{(S_WIDTH-P_WIDTH){1'b0}}, r_p};

    always_comb begin
        w_base = '0;
        if (r_clr_m) begin
            w_base = '0;
        end else if (r_acc_en_m) begin
            w_base = {((SIGNED != 0) && r_q[ACC_WIDTH-1]), r_q};
        end else begin
            w_base = {((SIGNED != 0) && r_c_m[ACC_WIDTH-1]), r_c_m};
        end
    end

    assign w_sum = w_p_ext + w_base;

    // Signed: the extra top bit disagreeing with the result sign means overflow.
    assign w_over    = (SIGNED != 0) ? (w_sum[S_WIDTH-1] ^ w_sum[S_WIDTH-2]) : w_sum[S_WIDTH-1];
    assign w_sat_val = (SIGNED == 0)      ? {ACC_WIDTH{1'b1}} :
                       w_sum[S_WIDTH-1]   ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                            {1'b0, {(ACC_WIDTH-1){1'b1}}};
    assign w_result  = (w_over && (SATURATE != 0)) ? w_sat_val : w_sum[ACC_WIDTH-1:0];

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            r_q         <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (ce) begin
            r_out_valid <= r_vld_m;
            if (r_vld_m) begin
                r_q   <= w_result;
                r_ovf <= r_clr_m ? w_over : (r_ovf | w_over);
            end else if (r_clr_m) begin
                r_q   <= '0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign q         = r_q;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_muladd_pipe.sv
// Directed bench for muladd_pipe: default, signed/saturating and input-registered
// instances share one stimulus; each scenario checks the instance it targets.
module tb_muladd_pipe;

    logic        UserCLK = 1'b0;
    logic        RESETn  = 1'b0;
    logic        ce      = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [19:0] c = '0;
    logic        acc_en = 1'b0;
    logic        clr    = 1'b0;

    logic        ov0, ov1, ov2;
    logic [19:0] q0, q1, q2;
    logic        of0, of1, of2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 UserCLK = ~UserCLK;

    muladd_pipe u_dut0 (
        .UserCLK(UserCLK), .RESETn(RESETn), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .acc_en(acc_en), .clr(clr),
        .out_valid(ov0), .q(q0), .ovf(of0)
    );

    muladd_pipe #(.SIGNED(1), .SATURATE(1)) u_dut1 (
        .UserCLK(UserCLK), .RESETn(RESETn), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .acc_en(acc_en), .clr(clr),
        .out_valid(ov1), .q(q1), .ovf(of1)
    );

    muladd_pipe #(.IN_REG(1)) u_dut2 (
        .UserCLK(UserCLK), .RESETn(RESETn), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .acc_en(acc_en), .clr(clr),
        .out_valid(ov2), .q(q2), .ovf(of2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s: %0d ok", tag, got);
        end
    endtask

    task automatic check_res(input int sel, input string tag, input logic ev,
                             input logic [31:0] eq, input logic eo);
        logic        gv;
        logic [19:0] gq;
        logic        go;
        case (sel)
            0:       begin gv = ov0; gq = q0; go = of0; end
            1:       begin gv = ov1; gq = q1; go = of1; end
            default: begin gv = ov2; gq = q2; go = of2; end
        endcase
        check_val({tag, ".valid"}, {31'b0, gv}, {31'b0, ev});
        check_val({tag, ".q"},     {12'b0, gq}, eq);
        check_val({tag, ".ovf"},   {31'b0, go}, {31'b0, eo});
    endtask

    task automatic tick;
        @(posedge UserCLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic cl, input logic ae,
                         input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv);
        in_valid = v;
        clr      = cl;
        acc_en   = ae;
        a        = av[7:0];
        b        = bv[7:0];
        c        = cv[19:0];
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    // Overflow / clear / priority sequence on the default instance.
    logic        t_v  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        t_cl [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        t_ae [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] t_a  [8] = '{32'd1, 32'd1, 32'd7, 32'd255, 32'd9, 32'd2, 32'd1, 32'd0};
    logic [31:0] t_b  [8] = '{32'd1, 32'd1, 32'd7, 32'd255, 32'd9, 32'd5, 32'd1, 32'd0};
    logic [31:0] t_c  [8] = '{32'd1048575, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1048575, 32'd123};
    logic        x_v  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] x_q  [8] = '{32'd0, 32'd6, 32'd0, 32'd65025, 32'd65025, 32'd10, 32'd0, 32'd0};
    logic        x_o  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [31:0] acc_exp [4];
        logic [31:0] eq;
        logic        eo;

        acc_exp = '{32'd4, 32'd13, 32'd22, 32'd31};

        // Reset state
        RESETn = 1'b0;
        ce     = 1'b1;
        idle();
        tick();
        tick();
        check_res(0, "rst_d0", 1'b0, 32'd0, 1'b0);
        check_res(1, "rst_d1", 1'b0, 32'd0, 1'b0);
        check_res(2, "rst_d2", 1'b0, 32'd0, 1'b0);
        RESETn = 1'b1;
        tick();

        // Single multiply-add, latency 2
        drive(1'b1, 1'b0, 1'b0, 32'd3, 32'd5, 32'd7);
        tick();
        idle();
        check_val("madd_lat1.valid", {31'b0, ov0}, 32'd0);
        tick();
        check_res(0, "madd", 1'b1, 32'd22, 1'b0);

        // Back-to-back clear then accumulate
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      drive(1'b1, 1'b1, 1'b0, 32'd2, 32'd2, 32'd0);
            else if (i <= 3) drive(1'b1, 1'b0, 1'b1, 32'd3, 32'd3, 32'd0);
            else             idle();
            tick();
            if (i >= 1 && i <= 4) check_res(0, $sformatf("acc%0d", i), 1'b1, acc_exp[i-1], 1'b0);
            else if (i == 5)      check_res(0, "acc_end", 1'b0, 32'd31, 1'b0);
        end

        // Signed saturating accumulation of (-128)*(-128)
        eq = 32'd0;
        eo = 1'b0;
        for (int i = 0; i < 35; i++) begin
            if (i == 0)       drive(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
            else if (i <= 33) drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 32'hFFFF_FF80, 32'd0);
            else              idle();
            tick();
            if (i >= 1) begin
                if (i >= 2) begin
                    eq = eq + 32'd16384;
                    if (eq > 32'd524287) begin
                        eq = 32'd524287;
                        eo = 1'b1;
                    end
                end
                check_res(1, $sformatf("sat%0d", i - 1), 1'b1, eq, eo);
            end
        end

        // Wrap overflow, sticky ovf, clear without valid, ignored beat, clr priority
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(t_v[i], t_cl[i], t_ae[i], t_a[i], t_b[i], t_c[i]);
            else       idle();
            tick();
            if (i >= 1) check_res(0, $sformatf("ovf%0d", i - 1), x_v[i-1], x_q[i-1], x_o[i-1]);
        end
        idle();
        tick();

        // Input-register instance: latency 3
        drive(1'b1, 1'b0, 1'b0, 32'd3, 32'd5, 32'd7);
        tick();
        idle();
        tick();
        check_val("inreg_lat2.valid", {31'b0, ov2}, 32'd0);
        tick();
        check_res(2, "inreg", 1'b1, 32'd22, 1'b0);

        // Two ce-low cycles stretch latency to 5; beats offered while frozen are ignored
        drive(1'b1, 1'b0, 1'b0, 32'd4, 32'd4, 32'd1);
        tick();
        ce = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0);
        tick();
        tick();
        check_res(2, "ce_frozen", 1'b0, 32'd22, 1'b0);
        ce = 1'b1;
        idle();
        tick();
        check_res(2, "ce_lat4", 1'b0, 32'd22, 1'b0);
        tick();
        check_res(2, "ce_lat5", 1'b1, 32'd17, 1'b0);
        ce = 1'b0;
        tick();
        check_val("ce_hold.valid", {31'b0, ov2}, 32'd1);
        ce = 1'b1;
        tick();
        tick();
        tick();
        check_res(2, "ce_ghost", 1'b0, 32'd17, 1'b0);

        // Asynchronous reset with beats in flight
        drive(1'b1, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'd1);
        tick();
        idle();
        check_res(0, "pre_rst", 1'b1, 32'd6, 1'b0);
        #2;
        RESETn = 1'b0;
        #1;
        check_res(0, "rst_async", 1'b0, 32'd0, 1'b0);
        check_res(2, "rst_async_d2", 1'b0, 32'd0, 1'b0);
        @(posedge UserCLK);
        #4;
        RESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_res(0, $sformatf("post_rel%0d", i), 1'b0, 32'd0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 32'd1);
        tick();
        idle();
        tick();
        check_res(0, "post_rst", 1'b1, 32'd10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
